out_chunk_collector: RTL and testbench



---
 rtl/out_collect_pkg.sv | 30 +++
 rtl/out_chunk_collector_if.sv | 30 +++
 rtl/out_chunk_collector_wide_fifo2.sv | 44 ++++
 rtl/out_chunk_collector.sv | 134 +++++++++++++
 tb/tb_out_chunk_collector.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/out_collect_pkg.sv
// Shared types, default geometry and helpers for the output chunk collector.
// Also hosts the ReLU element function used when OUT_COLLECT_RELU_EN is defined.
package out_collect_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_FRAC_WIDTH = 8;
   localparam int DEF_CHUNK_SIZE = 4;
   localparam int DEF_NUM_CORES  = 2;
   localparam int DEF_NUM_WORDS  = 6;

   localparam int CHUNK_W = DEF_WIDTH * DEF_CHUNK_SIZE;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_DONE = 1'b1
   } state_t;

   // A 1-value counter still needs a 1-bit register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Elements are carried zero-extended in 64 bits; w selects the sign bit.
   function automatic logic [63:0] relu_elem(input logic [63:0] v, input int unsigned w);
      logic [63:0] r;
      r = v[w-1] ? 64'd0 : v;
      return r;
   endfunction

endpackage

// File: rtl/out_chunk_collector_if.sv
// Wide-word input and chunk-stream output of the collector in one bundle.
// slave is the collector side; master is the upstream/downstream environment.
interface out_chunk_collector_if #(
   parameter int WIDTH      = 16,
   parameter int CHUNK_SIZE = 4,
   parameter int NUM_CORES  = 2
);
   localparam int CW = WIDTH * CHUNK_SIZE;
   localparam int DW = CW * NUM_CORES;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          m_valid;
   logic          m_ready;
   logic [CW-1:0] m_data;
   logic          m_last;
   logic          done;

   modport slave (
      input  in_valid, in_data, m_ready,
      output in_ready, m_valid, m_data, m_last, done
   );

   modport master (
      output in_valid, in_data, m_ready,
      input  in_ready, m_valid, m_data, m_last, done
   );

endinterface

// File: rtl/out_chunk_collector_wide_fifo2.sv
// Two-entry FIFO of wide result words; callers gate push on count!=2 and pop on count!=0.
module wide_fifo2 #(
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic [1:0]    o_count
);

   logic [DW-1:0] r_mem [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/out_chunk_collector.sv
// Buffers wide result words and serialises them one chunk per beat, flagging the matrix end.
// Optional OUT_COLLECT_RELU_EN clamps negative output elements to zero.
//
//   state  | meaning
//   S_RUN  | normal buffering and emission
//   S_DONE | one cycle after the m_last beat; drives done, traffic continues
module out_chunk_collector
   import out_collect_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int CHUNK_SIZE = DEF_CHUNK_SIZE,
   parameter int NUM_CORES  = DEF_NUM_CORES,
   parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
   input logic                  clk,
   input logic                  rst,
   out_chunk_collector_if.slave bus
);

   localparam int L_CHUNK_W = WIDTH * CHUNK_SIZE;
   localparam int L_DATA_W  = L_CHUNK_W * NUM_CORES;
   localparam int IDX_W     = idx_width(NUM_CORES);
   localparam int CNT_W     = idx_width(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(NUM_CORES - 1);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

   if (NUM_WORDS < 1) begin : g_bad_words
      $error("out_chunk_collector: NUM_WORDS must be at least 1");
   end
   if (FRAC_WIDTH >= WIDTH) begin : g_bad_frac
      $error("out_chunk_collector: FRAC_WIDTH must be below WIDTH");
   end

   logic [1:0]           w_count;
   logic [L_DATA_W-1:0]  w_head;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_m_valid;
   logic                 w_beat;
   logic                 w_m_last;
   logic                 w_last_beat;
   logic                 w_done;
   logic [L_CHUNK_W-1:0] w_slice;
   logic [L_CHUNK_W-1:0] w_chunk;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDX_W-1:0]     r_core_idx;
   logic [CNT_W-1:0]     r_word_cnt;

   wide_fifo2 #(
      .DW (L_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (bus.in_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign bus.in_ready = (w_count != 2'd2);
   assign w_push       = bus.in_valid & bus.in_ready;
   assign w_m_valid    = (w_count != 2'd0);
   assign w_beat       = w_m_valid & bus.m_ready;
   assign w_pop        = w_beat & (r_core_idx == LAST_CORE);
   assign w_m_last     = w_m_valid & (r_word_cnt == LAST_WORD) & (r_core_idx == LAST_CORE);
   assign w_last_beat  = w_beat & w_m_last;

   assign w_slice = w_head[r_core_idx*L_CHUNK_W +: L_CHUNK_W];

`ifdef OUT_COLLECT_RELU_EN
   if (WIDTH > 64) begin : g_bad_relu_width
      $error("out_chunk_collector: ReLU path supports WIDTH up to 64");
   end

   always_comb begin
      logic [63:0] v_elem;
      w_chunk = '0;
      v_elem  = '0;
      for (int e = 0; e < CHUNK_SIZE; e++) begin
         v_elem = relu_elem(64'(w_slice[e*WIDTH +: WIDTH]), WIDTH);
         w_chunk[e*WIDTH +: WIDTH] = v_elem[WIDTH-1:0];
      end
   end
`else
   assign w_chunk = w_slice;
`endif

   // Stale FIFO contents stay hidden while nothing is buffered.
   assign bus.m_data  = w_m_valid ? w_chunk : '0;
   assign bus.m_valid = w_m_valid;
   assign bus.m_last  = w_m_last;
   assign bus.done    = w_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_core_idx <= '0;
         r_word_cnt <= '0;
      end else if (w_beat) begin
         if (r_core_idx == LAST_CORE) begin
            r_core_idx <= '0;
            r_word_cnt <= (r_word_cnt == LAST_WORD) ? '0 : r_word_cnt + CNT_W'(1);
         end else begin
            r_core_idx <= r_core_idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_last_beat) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

endmodule

// File: tb/tb_out_chunk_collector.sv
// Directed bench for out_chunk_collector: expected chunks are queued at issue time
// and a negedge monitor compares every output beat and the done pulse.
module tb_out_chunk_collector;

   localparam int WIDTH      = 16;
   localparam int CHUNK_SIZE = 4;
   localparam int NUM_CORES  = 2;
   localparam int NUM_WORDS  = 6;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   out_chunk_collector_if #(
      .WIDTH      (WIDTH),
      .CHUNK_SIZE (CHUNK_SIZE),
      .NUM_CORES  (NUM_CORES)
   ) bus ();

   out_chunk_collector #(
      .WIDTH      (WIDTH),
      .FRAC_WIDTH (8),
      .CHUNK_SIZE (CHUNK_SIZE),
      .NUM_CORES  (NUM_CORES),
      .NUM_WORDS  (NUM_WORDS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   int   tb_words     = 0;
   logic exp_done     = 1'b0;
   int   mon_last_cnt = 0;

   function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   function automatic logic [63:0] model_chunk(input logic [63:0] raw);
      logic [63:0] r;
      r = raw;
`ifdef OUT_COLLECT_RELU_EN
      for (int e = 0; e < 4; e++) begin
         if (raw[e*16+15]) r[e*16 +: 16] = 16'h0000;
      end
`endif
      return r;
   endfunction

   task automatic push_exp(input logic [127:0] d);
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         e.data = model_chunk(d[c*64 +: 64]);
         e.last = (tb_words == NUM_WORDS - 1) && (c == NUM_CORES - 1);
         sb.push_back(e);
      end
      tb_words = (tb_words == NUM_WORDS - 1) ? 0 : tb_words + 1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic drive_word(input logic [127:0] d);
      int n;
      push_exp(d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("accept_wait_bound", 128'(n >= 100), 128'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      sb.delete();
      tb_words = 0;
      exp_done = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 128'(sb.size()), 128'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("done", 128'(bus.done), 128'(exp_done));
         exp_done = 1'b0;
         if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", 128'd1, 128'd0);
            end else begin
               e = sb.pop_front();
               chk("m_data", 128'(bus.m_data), 128'(e.data));
               chk("m_last", 128'(bus.m_last), 128'(e.last));
               if (e.last) begin
                  exp_done = 1'b1;
                  mon_last_cnt++;
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] w;
      logic [15:0]  exp_neg;

      bus.in_valid = 1'b1;
      bus.in_data  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      bus.m_ready  = 1'b0;

      // Reset held with in_valid high: nothing may enter or appear.
      rst = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_m_valid", 128'(bus.m_valid), 128'd0);
         chk("rst_m_last",  128'(bus.m_last),  128'd0);
         chk("rst_done",    128'(bus.done),    128'd0);
         chk("rst_m_data",  128'(bus.m_data),  128'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
      chk("post_rst_m_valid",  128'(bus.m_valid),  128'd0);
      @(posedge clk);
      #1;

      // Single word, latency and order.
      bus.m_ready = 1'b1;
      drive_word({64'h0008_0007_0006_0005, 64'h0004_0003_0002_0001});
      @(negedge clk);
      chk("single_t1_valid", 128'(bus.m_valid), 128'd1);
      chk("single_t1_data",  128'(bus.m_data),  128'h0004_0003_0002_0001);
      @(negedge clk);
      chk("single_t2_data",  128'(bus.m_data),  128'h0008_0007_0006_0005);
      @(negedge clk);
      chk("single_t3_valid", 128'(bus.m_valid), 128'd0);
      @(posedge clk);
      #1;

      // Backpressure: two words fill the FIFO, third waits for the first pop.
      bus.m_ready = 1'b0;
      drive_word({64'h0014_0013_0012_0011, 64'h0010_000F_000E_000D});
      drive_word({64'h0024_0023_0022_0021, 64'h0020_001F_001E_001D});
      w = {64'h0034_8033_0032_0031, 64'h0030_002F_F02E_002D};
      push_exp(w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
         chk("bp_m_data",   128'(bus.m_data),   128'h0010_000F_000E_000D);
         chk("bp_m_valid",  128'(bus.m_valid),  128'd1);
      end
      @(posedge clk);
      #1;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_release_in_ready", 128'(bus.in_ready), 128'(i == 2));
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_drain();

      // Full matrix plus one word past the wrap.
      do_reset(1);
      mon_last_cnt = 0;
      bus.m_ready  = 1'b1;
      for (int k = 0; k < 7; k++) begin
         drive_word({{4{16'h0100 + 16'(k)}}, {4{16'h0200 + 16'(k)}}});
      end
      wait_drain();
      chk("matrix_last_count", 128'(mon_last_cnt), 128'd1);

      // Reset after the third beat discards the rest.
      do_reset(1);
      bus.m_ready = 1'b0;
      drive_word({64'h0044_0043_0042_0041, 64'h0040_003F_003E_003D});
      drive_word({64'h0054_0053_0052_0051, 64'h0050_004F_004E_004D});
      bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_beats_taken", 128'(sb.size()), 128'd1);
      do_reset(1);
      @(negedge clk);
      chk("midrst_m_valid",  128'(bus.m_valid),  128'd0);
      chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
      @(posedge clk);
      #1;
      mon_last_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         drive_word({{4{16'h0300 + 16'(k)}}, {4{16'h0400 + 16'(k)}}});
      end
      wait_drain();
      chk("midrst_last_count", 128'(mon_last_cnt), 128'd1);

      // ReLU on a negative and a positive element.
`ifdef OUT_COLLECT_RELU_EN
      exp_neg = 16'h0000;
`else
      exp_neg = 16'hFF00;
`endif
      drive_word({64'h7FFF_8000_0000_0001, 64'h0180_FF00_0180_FF00});
      @(negedge clk);
      chk("relu_neg", 128'(bus.m_data[15:0]),  128'(exp_neg));
      chk("relu_pos", 128'(bus.m_data[31:16]), 128'h0180);
      @(posedge clk);
      #1;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
